// File: rtl/axi_wr_arb_pkg.sv
// Shared definitions for the two-requester AXI write arbiter:
// FSM state encoding, AXI burst/response codes and the outstanding-counter step.
package axi_wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

    // Next value of an outstanding-response counter. A simultaneous increment
    // and decrement cancel out; a decrement at zero is a protocol error from
    // downstream and is absorbed instead of wrapping.
    function automatic logic [3:0] cnt_next(input logic [3:0] cnt,
                                            input logic       inc,
                                            input logic       dec);
        logic [3:0] res;
        if (inc && !dec) begin
            res = cnt + 4'd1;
        end else if (dec && !inc && (cnt != 4'd0)) begin
            res = cnt - 4'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_wr_arb_rr.sv
// Two-way round-robin picker. The requester that did not win last time has
// priority; a lone requester always wins. Priority only moves when the
// caller reports that the grant was taken.
module axi_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic pri_q;
    logic pri_d;

    // Pick the winner and compute the priority for the next decision.
    always_comb begin
        gnt   = 2'b00;
        pri_d = pri_q;
        if (req == 2'b11) begin
            gnt = pri_q ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
        if (take && (gnt != 2'b00)) begin
            pri_d = gnt[0];
        end else begin
            pri_d = pri_q;
        end
    end

    // Priority register; requester 0 is favoured out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q <= 1'b0;
        end else begin
            pri_q <= pri_d;
        end
    end

endmodule

// File: rtl/axi_wr_arb.sv
// Arbitrates two AXI write requesters (capture, processed-frame writer) onto
// one shared write channel. One burst is in flight on AW/W at a time; B
// responses are routed back by the low bit of BID, and each requester is
// limited to MAX_OUT unanswered bursts.
module axi_wr_arb
    import axi_wr_arb_pkg::*;
#(
    parameter int AXI_AW  = 32,
    parameter int AXI_DW  = 64,
    parameter int AXI_IDW = 2,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_AW-1:0]     s0_awaddr,
    input  logic [7:0]            s0_awlen,
    input  logic [2:0]            s0_awsize,
    input  logic [1:0]            s0_awburst,
    input  logic                  s0_awvalid,
    output logic                  s0_awready,
    input  logic [AXI_DW-1:0]     s0_wdata,
    input  logic [AXI_DW/8-1:0]   s0_wstrb,
    input  logic                  s0_wlast,
    input  logic                  s0_wvalid,
    output logic                  s0_wready,
    output logic [1:0]            s0_bresp,
    output logic                  s0_bvalid,
    input  logic                  s0_bready,
    input  logic [AXI_AW-1:0]     s1_awaddr,
    input  logic [7:0]            s1_awlen,
    input  logic [2:0]            s1_awsize,
    input  logic [1:0]            s1_awburst,
    input  logic                  s1_awvalid,
    output logic                  s1_awready,
    input  logic [AXI_DW-1:0]     s1_wdata,
    input  logic [AXI_DW/8-1:0]   s1_wstrb,
    input  logic                  s1_wlast,
    input  logic                  s1_wvalid,
    output logic                  s1_wready,
    output logic [1:0]            s1_bresp,
    output logic                  s1_bvalid,
    input  logic                  s1_bready,
    output logic [AXI_IDW-1:0]    m_awid,
    output logic [AXI_AW-1:0]     m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [AXI_DW-1:0]     m_wdata,
    output logic [AXI_DW/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [AXI_IDW-1:0]    m_bid,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic [AXI_AW-1:0]   awaddr_q, awaddr_d;
    logic [7:0]          awlen_q, awlen_d;
    logic [2:0]          awsize_q, awsize_d;
    logic [1:0]          awburst_q, awburst_d;
    logic [3:0]          out0_q, out0_d;
    logic [3:0]          out1_q, out1_d;
    logic [1:0]          elig_s;
    logic [1:0]          gnt_s;
    logic                arb_take_s;
    logic                aw_acc_s;
    logic                b_hs_s;
    logic                unused_bid_s;

    // A requester may only compete while it has room for another response.
    always_comb begin
        elig_s[0] = s0_awvalid && (out0_q < 4'(MAX_OUT));
        elig_s[1] = s1_awvalid && (out1_q < 4'(MAX_OUT));
    end

    axi_rr_arb2 u_rr (
        .clk  (clk),
        .rst  (rst),
        .req  (elig_s),
        .take (arb_take_s),
        .gnt  (gnt_s)
    );

    // Burst FSM: accept one AW upstream, present it downstream, then stream W.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        awsize_d   = awsize_q;
        awburst_d  = awburst_q;
        arb_take_s = 1'b0;
        s0_awready = 1'b0;
        s1_awready = 1'b0;
        m_awvalid  = 1'b0;
        m_wdata    = '0;
        m_wstrb    = '0;
        m_wlast    = 1'b0;
        m_wvalid   = 1'b0;
        s0_wready  = 1'b0;
        s1_wready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rst && (gnt_s != 2'b00)) begin
                    arb_take_s = 1'b1;
                    s0_awready = gnt_s[0];
                    s1_awready = gnt_s[1];
                    grant_d    = gnt_s[1];
                    awaddr_d   = gnt_s[1] ? s1_awaddr  : s0_awaddr;
                    awlen_d    = gnt_s[1] ? s1_awlen   : s0_awlen;
                    awsize_d   = gnt_s[1] ? s1_awsize  : s0_awsize;
                    awburst_d  = gnt_s[1] ? s1_awburst : s0_awburst;
                    state_d    = ST_ADDR;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ADDR: begin
                m_awvalid = !rst;
                if (m_awready) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (rst) begin
                    m_wvalid = 1'b0;
                end else if (grant_q) begin
                    m_wdata   = s1_wdata;
                    m_wstrb   = s1_wstrb;
                    m_wlast   = s1_wlast;
                    m_wvalid  = s1_wvalid;
                    s1_wready = m_wready;
                end else begin
                    m_wdata   = s0_wdata;
                    m_wstrb   = s0_wstrb;
                    m_wlast   = s0_wlast;
                    m_wvalid  = s0_wvalid;
                    s0_wready = m_wready;
                end
                if (m_wvalid && m_wready && m_wlast) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Downstream AW fields come straight from the holding register.
    always_comb begin
        m_awid    = AXI_IDW'(grant_q);
        m_awaddr  = awaddr_q;
        m_awlen   = awlen_q;
        m_awsize  = awsize_q;
        m_awburst = awburst_q;
    end

    // Route the shared B channel to the requester named by BID bit 0.
    always_comb begin
        unused_bid_s = ^m_bid;
        s0_bresp     = m_bresp;
        s1_bresp     = m_bresp;
        s0_bvalid    = m_bvalid && !m_bid[0] && !rst;
        s1_bvalid    = m_bvalid &&  m_bid[0] && !rst;
        if (rst) begin
            m_bready = 1'b0;
        end else if (m_bid[0]) begin
            m_bready = s1_bready;
        end else begin
            m_bready = s0_bready;
        end
    end

    // Track unanswered bursts per requester: +1 on AW accept, -1 on B.
    always_comb begin
        aw_acc_s = m_awvalid && m_awready;
        b_hs_s   = m_bvalid && m_bready;
        out0_d   = cnt_next(out0_q, aw_acc_s && !grant_q, b_hs_s && !m_bid[0]);
        out1_d   = cnt_next(out1_q, aw_acc_s &&  grant_q, b_hs_s &&  m_bid[0]);
    end

    // State, grant, AW holding register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= 8'd0;
            awsize_q  <= 3'd0;
            awburst_q <= 2'd0;
            out0_q    <= 4'd0;
            out1_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            out0_q    <= out0_d;
            out1_q    <= out1_d;
        end
    end

endmodule

// File: doc/axi_wr_arb.md
AXI_WR_ARB -- requirements
Module: axi_wr_arb

Interface
REQ-001 The block SHALL have parameter AXI_AW, default 32, meaning the AXI address width.
REQ-002 The block SHALL have parameter AXI_DW, default 64, meaning the AXI data width.
REQ-003 The block SHALL have parameter AXI_IDW, default 2, meaning the master ID width (minimum 1).
REQ-004 The block SHALL have parameter MAX_OUT, default 4, meaning the maximum outstanding B responses per requester (1..15).
REQ-005 The block SHALL have ports clk (in, 1) and rst (in, 1), which are its one clock and its synchronous active-high reset.
REQ-006 The block SHALL have ports s0_awaddr/awlen/awsize/awburst (in, AXI_AW/8/3/2) and s0_awvalid (in, 1) / s0_awready (out, 1): requester 0 (capture) write address.
REQ-007 The block SHALL have ports s0_wdata/wstrb/wlast/wvalid (in, AXI_DW/AXI_DW/8/1/1) and s0_wready (out, 1): requester 0 write data.
REQ-008 The block SHALL have ports s0_bresp (out, 2), s0_bvalid (out, 1) and s0_bready (in, 1): requester 0 response.
REQ-009 The block SHALL have ports s1_* identical to s0_*: requester 1 (processed-frame writer).
REQ-010 The block SHALL have ports m_awid/awaddr/awlen/awsize/awburst/awvalid (out, AXI_IDW/AXI_AW/8/3/2/1) and m_awready (in, 1): shared AXI write address toward the HP port.
REQ-011 The block SHALL have ports m_wdata/wstrb/wlast/wvalid (out) and m_wready (in): shared write data.
REQ-012 The block SHALL have ports m_bid (in, AXI_IDW), m_bresp (in, 2), m_bvalid (in, 1) and m_bready (out, 1): shared write response.

Function
REQ-013 The block SHALL be an FSM with states IDLE, ADDR and DATA.
REQ-014 IDLE: eligible requester i = si_awvalid and outstanding_i < MAX_OUT; if any is eligible, the block SHALL set si_awready=1 for exactly one cycle for the winner, register its AW fields, record grant and go to ADDR.
REQ-015 Arbitration SHALL be round-robin: the requester other than the last winner has priority; after reset requester 0 has priority; a sole eligible requester always wins.
REQ-016 ADDR: m_awvalid=1 with the registered fields; m_awid = {zeros, grant}; on m_awready: go to DATA and increment outstanding_grant.
REQ-017 The registered AW fields SHALL remain stable while m_awvalid=1 and m_awready=0.
REQ-018 DATA: m_w* SHALL equal s{grant}_w* combinationally, s{grant}_wready = m_wready, and the other requester's wready=0.
REQ-019 DATA: on a handshake with m_wlast=1 the block SHALL return to IDLE; AW-to-AW minimum spacing is 3 cycles.
REQ-020 In IDLE and ADDR, m_wvalid=0 and both s*_wready=0.
REQ-021 B routing SHALL be: m_bid[0] selects requester; s{m_bid[0]}_bvalid = m_bvalid, m_bready = s{m_bid[0]}_bready, bresp passed through; other bvalid=0.
REQ-022 On a B handshake, outstanding_{m_bid[0]} SHALL decrement; a simultaneous AW accept and B handshake on the same requester SHALL leave its count unchanged.
REQ-023 A requester with outstanding = MAX_OUT SHALL be ineligible; the other requester SHALL still be granted.
REQ-024 A B handshake with outstanding = 0 (protocol error) SHALL not wrap the counter (saturate at 0).
REQ-025 The block SHALL have no combinational path from s*_awvalid to m_awvalid.

Reset
REQ-026 When rst=1 at a clk edge, the block SHALL enter IDLE, clear both outstanding counters, set priority to requester 0 and clear the AW register.
REQ-027 During and after reset, m_awvalid, m_wvalid, s*_awready, s*_wready and s*_bvalid SHALL be 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst without any further handshake; the upstream reset domain is responsible for the interconnect.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=0, ADDR=1, DATA=2) and the AXI burst/resp constants.
REQ-030 The block SHALL contain one sub-module, axi_rr_arb2, a 2-way round-robin picker with registered priority.
REQ-031 The rest of the block SHALL be flat, and the total SHALL be under 400 lines.

Verification
REQ-032 The bench SHALL cover: s0 single AW awlen=3 with 4 beats, m_awready immediate -> m_awid=0, 4 beats forwarded, m_wlast on beat 4, IDLE after.
REQ-033 The bench SHALL cover: s0 and s1 awvalid high continuously, 6 bursts of awlen=0 -> grant order 0,1,0,1,0,1.
REQ-034 The bench SHALL cover: m_awready held low 5 cycles -> m_awaddr stable for all 6 cycles, no W beat forwarded.
REQ-035 The bench SHALL cover: s0 issues 4 bursts, m_bvalid withheld -> fifth s0 AW stalled while s1 AW is granted; one B with bid=0 -> s0 granted next IDLE.
REQ-036 The bench SHALL cover: B with bid=1 and bresp=2 while s1_bready=0 for 3 cycles -> m_bready=0 for 3 cycles, s1_bresp=2, s0_bvalid=0.
REQ-037 The bench SHALL cover: rst pulse during beat 2 of an 8-beat burst -> next cycle IDLE, all valid/ready outputs 0, counters 0, next grant to s0.
